sirv_async_reset_regvec: RTL
============================

Name: sirv_async_reset_regvec

Overview:
Parametrised successor to the single-bit async-reset enable flop. It is a WIDTH-bit register with a configurable reset value and masked write/set/clear/toggle operations. It includes an internal reset-release synchronizer, so the register and its handshake leave reset cleanly in the clk domain. It is used for peripheral control/status registers (GPIO, PWM, AON config) where software performs atomic bit-level updates.

Parameters:
WIDTH, 32, register width in bits (1..64)
RESET_VAL, 0, value loaded into q while reset is active (WIDTH bits)
SYNC_STAGES, 2, reset-release synchronizer depth (2..4)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset; assertion is async, release is synchronized internally
op_valid  input  1  operation request
op_ready  output  1  block accepts operations; low while reset sync in progress
op_code  input  2  00 write, 01 set, 10 clear, 11 toggle
op_mask  input  WIDTH  per-bit enable for the operation
op_data  input  WIDTH  operand
q  output  WIDTH  current register value
old_q  output  WIDTH  value of q before the most recent accepted op
chg  output  1  one-cycle pulse: last accepted op changed at least one bit of q
rst_done  output  1  synchronized reset-release indicator

Behaviour:
- Reset assertion (rst_n=0), asynchronous: all synchronizer flops=0, q=RESET_VAL, old_q=RESET_VAL, chg=0, rst_done=0, op_ready=0.
- Reset release: rst_done rises on the SYNC_STAGES-th rising clk edge after rst_n goes high. op_ready = rst_done.
- Accept = op_valid & op_ready. Ops presented while op_ready=0 are dropped silently, with no state change.
- On an accepted op, at the next edge, each bit i is updated as follows:
  - op_mask[i]=0: q[i] unchanged.
  - write: q[i]=op_data[i].
  - set: q[i]=q[i] | op_data[i].
  - clear: q[i]=q[i] & ~op_data[i].
  - toggle: q[i]=q[i] ^ op_data[i].
- Latency: q reflects the op 1 cycle after accept. Back-to-back ops every cycle are supported; each op uses the q produced by the previous op.
- old_q is loaded with the pre-op q on each accepted op and holds otherwise.
- chg=1 for exactly the cycle after an accepted op whose new q differs from the pre-op q; 0 otherwise, including for ops with an all-zero mask.
- Reset asserted mid-stream: q returns to RESET_VAL immediately and asynchronously. Any op in that cycle is lost. The synchronizer restarts from 0.
- Reset glitch shorter than one clk period still forces RESET_VAL and restarts the full SYNC_STAGES wait.
- All arithmetic is bitwise, with no carries; width is exactly WIDTH throughout.
- No combinational path from op_* to q/old_q/chg. op_ready depends only on flop state.

Decomposition:
- Shared package sirv_regvec_pkg: op_code encodings (OP_WRITE=2'b00, OP_SET=2'b01, OP_CLR=2'b10, OP_TGL=2'b11).
- Sub-module sirv_reset_sync (parameter SYNC_STAGES; ports clk, rst_n, rst_done): async-assert/sync-release chain. It is reused by other peripherals.
- The bit-update logic stays in the top level as a per-bit generate.

Test Plan:
- Reset/release, WIDTH=8, RESET_VAL=8'hA5, SYNC_STAGES=3: hold rst_n=0 → q=8'hA5, op_ready=0. Release rst_n → rst_done=1 on the 3rd rising edge. An op issued on cycles 1-2 is dropped and q stays 8'hA5.
- Masked ops from q=8'hA5:
  - write data=8'h0F, mask=8'hF0 → q=8'h05.
  - set data=8'hF0, mask=8'hFF → q=8'hF5.
  - clear data=8'h81, mask=8'hFF → q=8'h74.
  - toggle data=8'hFF, mask=8'h0F → q=8'h7B.
  - old_q tracks 8'hA5, 8'h05, 8'hF5, 8'h74 respectively.
- chg pulse: set data=8'h01 on q=8'h01 → chg=0. Clear data=8'h01 → chg=1 for one cycle. Any op with mask=0 → chg=0 and q unchanged.
- Mid-operation reset: assert rst_n low for 0.3 clk period during a valid write → q=RESET_VAL immediately, chg=0. rst_done re-asserts after exactly SYNC_STAGES edges.
- Width corners: WIDTH=1 and WIDTH=64 with RESET_VAL all-ones. Random op stream (10k ops) checked against a reference model, including back-to-back toggles on the same bits.

Source files
------------

// File: rtl/sirv_regvec_pkg.sv
// Shared op encodings and the single-bit update rule for masked register-vector operations.
// Pure combinational helpers; no state, no latency.
package sirv_regvec_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_SET   = 2'b01,
      OP_CLR   = 2'b10,
      OP_TGL   = 2'b11
   } op_code_e;

   function automatic logic bit_update(input op_code_e op, input logic cur, input logic dat);
      logic res;
      res = cur;
      case (op)
         OP_WRITE: res = dat;
         OP_SET:   res = cur | dat;
         OP_CLR:   res = cur & ~dat;
         OP_TGL:   res = cur ^ dat;
         default:  res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sirv_reset_sync.sv
// Async-assert / sync-release reset chain; rst_done rises SYNC_STAGES clk edges after rst_n releases.
// Assertion clears the chain immediately, so even a sub-cycle glitch restarts the full wait.
module sirv_reset_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic rst_done
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_done = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sirv_async_reset_regvec.sv
// Masked write/set/clear/toggle register with async reset to RESET_VAL; q updates one cycle after accept.
// op_ready follows the synchronized reset release; ops offered while it is low are dropped.
module sirv_async_reset_regvec
   import sirv_regvec_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       op_code,
   input  logic [WIDTH-1:0] op_mask,
   input  logic [WIDTH-1:0] op_data,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] old_q,
   output logic             chg,
   output logic             rst_done
);

   logic             accept;
   logic [WIDTH-1:0] nxt;
   op_code_e         op;

   sirv_reset_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_reset_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .rst_done (rst_done)
   );

   assign op_ready = rst_done;
   assign accept   = op_valid & rst_done;
   assign op       = op_code_e'(op_code);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign nxt[i] = op_mask[i] ? bit_update(op, q[i], op_data[i]) : q[i];
   end

   // Raw rst_n resets the data path; release is harmless since accept stays low until rst_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= RESET_VAL;
         old_q <= RESET_VAL;
         chg   <= 1'b0;
      end else if (accept) begin
         q     <= nxt;
         old_q <= q;
         chg   <= (nxt != q);
      end else begin
         chg   <= 1'b0;
      end
   end

endmodule
